// File: rtl/sram_bus_ctrl_pkg.sv
// Shared types and constants for the SRAM bus controller.
//   state_t        : controller FSM encoding (IDLE/TURN/SETUP/ACCESS/HOLD)
//   CNT_W          : width of the access wait-state counter
//   WAIT_MAX       : largest supported WAIT_CYC value
//   strobe_state() : states in which the chip enable is asserted
package sram_bus_ctrl_pkg;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_TURN   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  // Chip enable is low only while address/data are presented to the SRAM.
  function automatic logic strobe_state(input state_t s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// Request-side bus between the CPU/datapath and the SRAM controller.
//   req/we/addr_in/wdata : transfer request from the master
//   ack/rdata/busy       : completion pulse, read data and busy status from the slave
// Modports: master (requester), slave (controller).
interface sram_bus_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output req, we, addr_in, wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, we, addr_in, wdata,
    output ack, rdata, busy
  );

endinterface

// File: rtl/sram_bus_ctrl_wait_cnt.sv
// Wait-state counter for the ACCESS phase.
//   clk, rst : clock, async active-low reset
//   clr      : force count to zero (takes priority over inc)
//   inc      : advance count while not yet done
//   done_c   : count has reached WAIT_CYC (clamped to WAIT_MAX)
module sram_bus_ctrl_wait_cnt
  import sram_bus_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done_c
);

  localparam int unsigned WAIT_LIM = (WAIT_CYC > WAIT_MAX) ? WAIT_MAX : WAIT_CYC;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_c = (cnt_q == CNT_W'(WAIT_LIM));

  // Next count: clear, count up, or hold at terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !done_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_bus_ctrl.sv
// Parametrised asynchronous-SRAM bus controller with req/ack handshake.
//   clk, rst  : clock, async active-low reset
//   bus       : sram_bus_ctrl_if.slave (req/we/addr_in/wdata in, ack/rdata/busy out)
//   addr      : registered SRAM address
//   cen/wen/oen : registered active-low SRAM strobes
//   dq        : SRAM data, driven only during write SETUP/ACCESS/HOLD
// Optional feature: define SRAM_TURNAROUND_EN to insert one idle TURN cycle
// before a write that directly follows a read.
module sram_bus_ctrl
  import sram_bus_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  sram_bus_ctrl_if.slave    bus,
  output logic [ADDR_W-1:0] addr,
  output logic              cen,
  output logic              wen,
  output logic              oen,
  inout  wire  [DATA_W-1:0] dq
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic              oen_q, oen_d;
  logic              drv_q, drv_d;
  logic              cnt_clr, cnt_inc, cnt_done_c;
`ifdef SRAM_TURNAROUND_EN
  logic              last_rd_q, last_rd_d;
`endif

  sram_bus_ctrl_wait_cnt #(
    .WAIT_CYC (WAIT_CYC)
  ) u_wait_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .done_c (cnt_done_c)
  );

  assign dq        = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign addr      = addr_q;
  assign cen       = cen_q;
  assign wen       = wen_q;
  assign oen       = oen_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  // Next-state and registered-output logic; strobes derive from the next state
  // so that they are valid in the same cycle the FSM enters a state.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b1;
    cnt_inc = 1'b0;
`ifdef SRAM_TURNAROUND_EN
    last_rd_d = last_rd_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr_in;
          wdata_d = bus.wdata;
`ifdef SRAM_TURNAROUND_EN
          last_rd_d = !bus.we;
          if (bus.we) begin
            state_d = last_rd_q ? ST_TURN : ST_SETUP;
          end else begin
            state_d = ST_ACCESS;
          end
`else
          state_d = bus.we ? ST_SETUP : ST_ACCESS;
`endif
        end
      end
      ST_TURN: begin
        state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b1;
        if (cnt_done_c) begin
          state_d = ST_HOLD;
          if (!we_q) begin
            rdata_d = dq;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d  = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
    cen_d  = !strobe_state(state_d);
    wen_d  = !((state_d == ST_ACCESS) && we_d);
    oen_d  = !((state_d == ST_ACCESS) && !we_d);
    // Data stays driven through HOLD for write data hold time.
    drv_d  = we_d && (strobe_state(state_d) || (state_d == ST_HOLD));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      oen_q   <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      oen_q   <= oen_d;
      drv_q   <= drv_d;
    end
  end

`ifdef SRAM_TURNAROUND_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_rd_q <= 1'b0;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end
`endif

endmodule

// File: tb/tb_sram_bus_ctrl.sv
// Self-checking bench for sram_bus_ctrl (ADDR_W=12, DATA_W=16, WAIT_CYC=3)
// with a behavioural async SRAM and a scoreboard-driven monitor.
module tb_sram_bus_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          cen, wen, oen;
  wire  [DW-1:0] dq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t          q[$];
  logic [DW-1:0] ref_mem [0:4095];
  logic [DW-1:0] mem     [0:4095];
  logic          last_rd = 1'b0;

  sram_bus_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_bus_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .WAIT_CYC (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .addr (addr),
    .cen  (cen),
    .wen  (wen),
    .oen  (oen),
    .dq   (dq)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural SRAM: drives dq on read, captures dq mid-cycle on write.
  assign dq = (!cen && !oen) ? mem[addr] : {DW{1'bz}};

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7) ^ 16'hA5A5;
    forever begin
      @(negedge clk);
      if (rst && !cen && !wen) mem[addr] = dq;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: tracks strobes per transfer and scores each ack against the queue.
  initial begin
    int   t0, oen_cnt, wen_cnt;
    logic wbad, busy_prev;
    exp_t e;
    t0 = 0; oen_cnt = 0; wen_cnt = 0; wbad = 1'b0; busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy_prev = 1'b0; oen_cnt = 0; wen_cnt = 0; wbad = 1'b0;
      end else begin
        if (bus.busy && !busy_prev) begin
          t0 = cyc; oen_cnt = 0; wen_cnt = 0; wbad = 1'b0;
        end
        if (bus.busy) begin
          if (!oen) oen_cnt++;
          if (!wen) begin
            wen_cnt++;
            if (q.size() > 0 && dq !== q[0].data) wbad = 1'b1;
          end
        end
        if (!wen && !oen) begin
          checks++; errors++;
          $display("FAIL strobe_excl: wen and oen both low (t=%0t)", $time);
        end
        if (bus.ack) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack: ack with empty scoreboard (t=%0t)", $time);
          end else begin
            e = q.pop_front();
            check("latency", 32'(cyc - t0 + 1), 32'(e.lat));
            check("addr_out", 32'(addr), 32'(e.addr));
            if (!e.we) begin
              check("rdata", 32'(bus.rdata), 32'(e.data));
              check("oen_cycles", 32'(oen_cnt), 32'(W + 1));
              check("wen_cycles_rd", 32'(wen_cnt), 32'(0));
            end else begin
              check("wen_cycles", 32'(wen_cnt), 32'(W + 1));
              check("oen_cycles_wr", 32'(oen_cnt), 32'(0));
              check("wdata_on_dq", 32'(wbad), 32'(0));
            end
          end
        end
        busy_prev = bus.busy;
      end
    end
  end

  // Issue one transfer (called at a negedge) and wait for its ack; req is left high.
  task automatic xfer(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit toggle = 1'b0);
    exp_t e;
    int   n;
    e.we   = w;
    e.addr = a;
    e.lat  = w ? int'(W) + 3 : int'(W) + 2;
`ifdef SRAM_TURNAROUND_EN
    if (w && last_rd) e.lat = e.lat + 1;
`endif
    if (w) begin
      ref_mem[a] = d;
      e.data     = d;
    end else begin
      e.data = ref_mem[a];
    end
    last_rd = !w;
    q.push_back(e);
    bus.req = 1'b1; bus.we = w; bus.addr_in = a; bus.wdata = d;
    n = 0;
    @(negedge clk);
    while (!bus.ack && n < 100) begin
      if (toggle) begin
        bus.req     = ~bus.req;
        bus.we      = ~bus.we;
        bus.addr_in = bus.addr_in ^ 12'hFFF;
        bus.wdata   = ~bus.wdata;
      end
      @(negedge clk);
      n++;
    end
    if (!bus.ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack for addr %h (t=%0t)", a, $time);
      bus.req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    bus.req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'(i * 7) ^ 16'hA5A5;
    rst = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr_in = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);

    check("rst_cen", 32'(cen), 32'(1));
    check("rst_wen", 32'(wen), 32'(1));
    check("rst_oen", 32'(oen), 32'(1));
    check("rst_addr", 32'(addr), 32'(0));
    check("rst_rdata", 32'(bus.rdata), 32'(0));
    check("rst_ack", 32'(bus.ack), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_dq_z", 32'(dq === 16'hzzzz), 32'(1));

    rst = 1'b1;
    idle(2);

    // Write then read back-to-back at the same address.
    xfer(1'b1, 12'h010, 16'h00A5);
    xfer(1'b0, 12'h010, 16'h0000);
    idle(2);

    // Request inputs wiggle while busy: exactly one transfer, captured address.
    xfer(1'b0, 12'h03F, 16'h0000, 1'b1);
    idle(4);
    check("addr_hold_idle", 32'(addr), 32'(12'h03F));
    check("no_extra_xfer", 32'(q.size()), 32'(0));

    // Mixed sequence: read->write (turnaround when enabled), write->write, reads.
    xfer(1'b0, 12'h020, 16'h0000);
    xfer(1'b1, 12'h021, 16'hBEEF);
    xfer(1'b1, 12'h022, 16'h1357);
    xfer(1'b0, 12'h021, 16'h0000);
    xfer(1'b0, 12'h022, 16'h0000);
    idle(2);

    // Writes leave the read data register alone.
    xfer(1'b1, 12'hABC, 16'hBEEF);
    idle(1);
    check("rdata_hold", 32'(bus.rdata), 32'(16'h1357));
    xfer(1'b0, 12'hABC, 16'h0000);
    idle(2);

    // Reset during write ACCESS: strobes release immediately, no ack.
    bus.req = 1'b1; bus.we = 1'b1; bus.addr_in = 12'h555; bus.wdata = 16'h1234;
    n = 0;
    @(negedge clk);
    while (wen && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_access", 32'(wen), 32'(0));
    rst = 1'b0;
    #1;
    check("abort_cen", 32'(cen), 32'(1));
    check("abort_wen", 32'(wen), 32'(1));
    check("abort_oen", 32'(oen), 32'(1));
    check("abort_dq_z", 32'(dq === 16'hzzzz), 32'(1));
    check("abort_ack", 32'(bus.ack), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    bus.req = 1'b0;
    last_rd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(2);

    xfer(1'b1, 12'h555, 16'h4321);
    xfer(1'b0, 12'h555, 16'h0000);
    xfer(1'b0, 12'h7FF, 16'h0000);
    idle(4);
    check("sb_empty", 32'(q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
